multi_channel_counter_with_strobe: RTL and testbench
====================================================

MULTI_CHANNEL_COUNTER_WITH_STROBE -- requirements
Module: multi_channel_counter_with_strobe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter and period width in bits (legal range 2..32).
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent counter channels (legal range 1..16).
REQ-003 SHALL have parameter LATENCY, default 2: extra pipeline stages in the increment path (legal range 0..WIDTH-1).
REQ-004 SHALL have local CW = max(1, clog2(CHANNELS)): width of the channel-select field.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset: synchronous, active-low.
REQ-007 SHALL have port tick  input  CHANNELS  per-channel count enable; bit n belongs to channel n.
REQ-008 SHALL have port ready  output  CHANNELS  bit n high when channel n will accept a tick this cycle.
REQ-009 SHALL have port strobe  output  CHANNELS  one-cycle terminal-count pulse per channel.
REQ-010 SHALL have port running  output  CHANNELS  channel n is armed and counting.
REQ-011 SHALL have port count  output  CHANNELS*WIDTH  committed count; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-012 SHALL have port cfg_valid  input  1  configuration request.
REQ-013 SHALL have port cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-014 SHALL have port cfg_chan  input  CW  target channel of the configuration.
REQ-015 SHALL have port cfg_period  input  WIDTH  terminal period P; value 0 means 2^WIDTH.
REQ-016 SHALL have port cfg_oneshot  input  1  1 = stop after the first strobe; 0 = periodic.
REQ-017 SHALL have port cfg_start  input  1  1 = arm the channel on write; 0 = stop it.

Function
REQ-018 SHALL accept a config write on a clock edge where cfg_valid and cfg_ready are both high and rst is high.
REQ-019 SHALL, on a config write, load P and the mode, clear count to 0, set running to cfg_start, and discard any in-flight tick, all visible on the next cycle.
REQ-020 SHALL ignore a config write whose cfg_chan is at or above CHANNELS, while still accepting the handshake.
REQ-021 SHALL drive cfg_ready high in every cycle after reset is released, and low during reset.
REQ-022 SHALL accept a tick on channel n at an edge only where tick[n], ready[n] and running[n] are all high.
REQ-023 SHALL silently drop a tick that arrives while the channel is not ready or not running.
REQ-024 SHALL, for a tick accepted in cycle t, make the count update and any strobe visible in cycle t+1+LATENCY.
REQ-025 SHALL hold ready[n] low in cycles t+1 through t+LATENCY after an accepted tick, and high in cycle t+LATENCY+1 if the channel is still running.
REQ-026 SHALL keep ready[n] continuously high while running when LATENCY=0, so one tick per cycle is accepted.
REQ-027 SHALL split the increment into LATENCY+1 carry-chained slices, with no full-width adder in a single stage when LATENCY>0.
REQ-028 SHALL use the following per-channel states: IDLE (running=0, ready=0); ARMED (running=1, ready=1); PEND (tick in flight, ready=0).
REQ-029 SHALL use the following transitions: IDLE->ARMED on a start write; ARMED->PEND on an accepted tick when LATENCY>0; PEND->ARMED at commit; any state->IDLE on a stop write; commit->IDLE on a one-shot strobe.
REQ-030 SHALL use the commit rule: if count+1 == P (modulo 2^WIDTH), set count to 0 and pulse strobe[n] for exactly 1 cycle; otherwise count becomes count+1.
REQ-031 SHALL, for P=1, strobe on every accepted tick with count staying 0.
REQ-032 SHALL, for P=0, strobe on the tick that wraps count from 2^WIDTH-1 to 0.
REQ-033 SHALL, in one-shot mode, clear running in the strobe cycle and hold count at 0 until the next config write.
REQ-034 SHALL, when a config write and an accepted tick hit the same channel on the same edge, let the config win, dropping the tick and producing no strobe.
REQ-035 SHALL keep channels fully independent: a config write to one channel never alters another channel's state, count, ready or strobe.
REQ-036 SHALL register strobe, ready, running and count, with no combinational path from any input to any output.

Reset
REQ-037 SHALL, while rst is low at an edge, set all channels to IDLE with count=0, P=0, periodic mode, strobe=0, ready=0, running=0 and cfg_ready=0, and discard all in-flight ticks.
REQ-038 SHALL treat reset asserted mid-operation identically to power-up, with no strobe emitted for in-flight ticks.
REQ-039 SHALL power up with registers at the same values as reset.

Verification
REQ-040 SHALL be verified with WIDTH=8, LATENCY=0, ch0 P=3 periodic, tick held high: strobe[0] in cycles 3, 6, 9 after the first tick, and count sequence 1, 2, 0, 1, ...
REQ-041 SHALL be verified with LATENCY=2, ch1 P=2, tick held high: ready[1] pattern 1,0,0 repeating, and strobe[1] 3 cycles after every 2nd accepted tick.
REQ-042 SHALL be verified with ch2 one-shot P=4 and 6 ticks: exactly 1 strobe, running[2]=0 afterwards, count=0, and the last 2 ticks ignored.
REQ-043 SHALL be verified with WIDTH=4, P=0, 16 ticks: strobe on the 16th tick only.
REQ-044 SHALL be verified with a config write to ch0 on the same edge as an accepted tick at count=P-1: no strobe, and count=0 next cycle.
REQ-045 SHALL be verified with rst low for 1 cycle while ch3 has a tick in PEND: all outputs at reset values next cycle, no strobe, and cfg_ready high 1 cycle after release.

Source files
------------

// File: rtl/multi_channel_counter_with_strobe_if.sv
// Signal bundle for the multi-channel counter: per-channel tick/status lines
// plus the configuration valid/ready handshake.
interface multi_channel_counter_with_strobe_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       ready;
    logic [CHANNELS-1:0]       strobe;
    logic [CHANNELS-1:0]       running;
    logic [CHANNELS*WIDTH-1:0] count;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [CW-1:0]             cfg_chan;
    logic [WIDTH-1:0]          cfg_period;
    logic                      cfg_oneshot;
    logic                      cfg_start;

    modport master (
        output tick, cfg_valid, cfg_chan, cfg_period, cfg_oneshot, cfg_start,
        input  ready, strobe, running, count, cfg_ready
    );

    modport slave (
        input  tick, cfg_valid, cfg_chan, cfg_period, cfg_oneshot, cfg_start,
        output ready, strobe, running, count, cfg_ready
    );
endinterface

// File: rtl/multi_channel_counter_with_strobe.sv
// Independent per-channel tick counters with programmable terminal period and
// a sliced, pipelined increment path of LATENCY extra stages.
//
// state | meaning
// IDLE  | stopped: running=0, ready=0
// ARMED | counting, accepts a tick: running=1, ready=1
// PEND  | tick in flight through the increment pipeline: running=1, ready=0
module multi_channel_counter_with_strobe #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 2
) (
    input logic                               clk,
    input logic                               rst,
    multi_channel_counter_with_strobe_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NS = LATENCY + 1;
    localparam int SW = (WIDTH + NS - 1) / NS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PEND  = 2'd2
    } state_t;

    // Slice k covers bits [k*SW, (k+1)*SW); slices past WIDTH are empty.
    function automatic logic [WIDTH-1:0] slice_sum(input logic [WIDTH-1:0] val,
                                                   input logic cin, input int k);
        logic [WIDTH-1:0] v;
        logic             c;
        v = val;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= k * SW && i < (k + 1) * SW) begin
                v[i] = val[i] ^ c;
                c    = val[i] & c;
            end
        end
        return v;
    endfunction

    function automatic logic slice_carry(input logic [WIDTH-1:0] val,
                                         input logic cin, input int k);
        logic c;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= k * SW && i < (k + 1) * SW)
                c = val[i] & c;
        end
        return c;
    endfunction

    logic cfg_rdy_q;
    logic cfg_wr;

    always_ff @(posedge clk) begin
        if (!rst) cfg_rdy_q <= 1'b0;
        else      cfg_rdy_q <= 1'b1;
    end

    assign bus.cfg_ready = cfg_rdy_q;
    assign cfg_wr        = bus.cfg_valid && cfg_rdy_q;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        state_t           st, st_nxt;
        logic [WIDTH-1:0] cnt, cnt_nxt;
        logic [WIDTH-1:0] per, per_nxt;
        logic             one, one_nxt;
        logic             stb, stb_nxt;
        logic             rdy, run;
        logic             hit, acc, cmt;
        logic [WIDTH-1:0] sum_fin;

        assign hit = cfg_wr && (bus.cfg_chan == CW'(n));
        assign acc = bus.tick[n] && rdy && run;

        if (LATENCY == 0) begin : g_nopipe
            assign cmt     = acc;
            assign sum_fin = slice_sum(cnt, 1'b1, 0);
        end else begin : g_pipe
            logic [WIDTH-1:0]   stg_val [LATENCY];
            logic [LATENCY-1:0] stg_c;
            logic [LATENCY-1:0] stg_v;

            // A config write to this channel kills whatever is in flight.
            always_ff @(posedge clk) begin
                if (!rst || hit) begin
                    stg_v <= '0;
                end else begin
                    stg_v[0] <= acc;
                    for (int k = 1; k < LATENCY; k++)
                        stg_v[k] <= stg_v[k-1];
                end
            end

            always_ff @(posedge clk) begin
                stg_val[0] <= slice_sum(cnt, 1'b1, 0);
                stg_c[0]   <= slice_carry(cnt, 1'b1, 0);
                for (int k = 1; k < LATENCY; k++) begin
                    stg_val[k] <= slice_sum(stg_val[k-1], stg_c[k-1], k);
                    stg_c[k]   <= slice_carry(stg_val[k-1], stg_c[k-1], k);
                end
            end

            assign cmt     = stg_v[LATENCY-1];
            assign sum_fin = slice_sum(stg_val[LATENCY-1], stg_c[LATENCY-1], LATENCY);
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                st  <= IDLE;
                cnt <= '0;
                per <= '0;
                one <= 1'b0;
                stb <= 1'b0;
            end else begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
                per <= per_nxt;
                one <= one_nxt;
                stb <= stb_nxt;
            end
        end

        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            per_nxt = per;
            one_nxt = one;
            stb_nxt = 1'b0;
            if (hit) begin
                per_nxt = bus.cfg_period;
                one_nxt = bus.cfg_oneshot;
                cnt_nxt = '0;
                st_nxt  = bus.cfg_start ? ARMED : IDLE;
            end else begin
                if (acc)
                    st_nxt = PEND;
                // Period 0 falls out naturally: the wrap to 0 matches P=0.
                if (cmt) begin
                    if (sum_fin == per) begin
                        cnt_nxt = '0;
                        stb_nxt = 1'b1;
                        st_nxt  = one ? IDLE : ARMED;
                    end else begin
                        cnt_nxt = sum_fin;
                        st_nxt  = ARMED;
                    end
                end
            end
        end

        always_comb begin
            rdy = 1'b0;
            run = 1'b0;
            case (st)
                ARMED: begin
                    rdy = 1'b1;
                    run = 1'b1;
                end
                PEND:    run = 1'b1;
                default: ;
            endcase
        end

        assign bus.ready[n]                  = rdy;
        assign bus.running[n]                = run;
        assign bus.strobe[n]                 = stb;
        assign bus.count[n*WIDTH +: WIDTH]   = cnt;
    end
endmodule

// File: tb/tb_multi_channel_counter_with_strobe.sv
// Bench for the multi-channel counter: two instances (8-bit/no pipeline and
// 4-bit/3-channel/two-stage pipeline) driven from a vector table and a scoreboard.
module tb_multi_channel_counter_with_strobe;
    typedef struct {
        int         id;
        bit         dut;
        logic       rst;
        logic [3:0] tick;
        bit         cv;
        logic [1:0] cch;
        logic [7:0] cper;
        bit         cone;
        bit         cst;
        logic [3:0] e_stb;
        logic [3:0] e_rdy;
        logic [3:0] e_run;
        int         ech;
        logic [7:0] e_cnt;
        bit         e_crdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   row_id   = 0;
    vec_t tab[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    multi_channel_counter_with_strobe_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
    multi_channel_counter_with_strobe_if #(.WIDTH(4), .CHANNELS(3)) bus_b ();

    multi_channel_counter_with_strobe #(.WIDTH(8), .CHANNELS(4), .LATENCY(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    multi_channel_counter_with_strobe #(.WIDTH(4), .CHANNELS(3), .LATENCY(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    function automatic vec_t mk(bit d, logic r, logic [3:0] tk, bit cv, logic [1:0] cc,
                                logic [7:0] cp, bit co, bit cs, logic [3:0] es,
                                logic [3:0] er, logic [3:0] eu, int ech, logic [7:0] ec,
                                bit ecr);
        vec_t v;
        v.id = row_id; row_id++;
        v.dut = d; v.rst = r; v.tick = tk; v.cv = cv; v.cch = cc; v.cper = cp;
        v.cone = co; v.cst = cs; v.e_stb = es; v.e_rdy = er; v.e_run = eu;
        v.ech = ech; v.e_cnt = ec; v.e_crdy = ecr;
        return v;
    endfunction

    function automatic vec_t tk(bit d, logic [3:0] t, logic [3:0] es, logic [3:0] er,
                                logic [3:0] eu, int ech, logic [7:0] ec);
        return mk(d, 1'b1, t, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, es, er, eu, ech, ec, 1'b1);
    endfunction

    function automatic vec_t cf(bit d, logic [1:0] cc, logic [7:0] cp, bit co, bit cs,
                                logic [3:0] es, logic [3:0] er, logic [3:0] eu,
                                int ech, logic [7:0] ec);
        return mk(d, 1'b1, 4'h0, 1'b1, cc, cp, co, cs, es, er, eu, ech, ec, 1'b1);
    endfunction

    task automatic chk(input int id, input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL row%0d %s got=%0h exp=%0h", id, nm, got, exp);
        end
    endtask

    task automatic cycle_cmp(input vec_t v);
        vec_t       e;
        logic [3:0] g_stb, g_rdy, g_run;
        logic [7:0] g_cnt;
        logic       g_crdy;
        rst = v.rst;
        bus_a.tick = 4'h0; bus_a.cfg_valid = 1'b0;
        bus_b.tick = 3'h0; bus_b.cfg_valid = 1'b0;
        if (v.dut == 1'b0) begin
            bus_a.tick = v.tick; bus_a.cfg_valid = v.cv; bus_a.cfg_chan = v.cch;
            bus_a.cfg_period = v.cper; bus_a.cfg_oneshot = v.cone; bus_a.cfg_start = v.cst;
        end else begin
            bus_b.tick = v.tick[2:0]; bus_b.cfg_valid = v.cv; bus_b.cfg_chan = v.cch;
            bus_b.cfg_period = v.cper[3:0]; bus_b.cfg_oneshot = v.cone; bus_b.cfg_start = v.cst;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.dut == 1'b0) begin
            g_stb = bus_a.strobe; g_rdy = bus_a.ready; g_run = bus_a.running;
            g_cnt = bus_a.count[e.ech*8 +: 8]; g_crdy = bus_a.cfg_ready;
        end else begin
            g_stb = {1'b0, bus_b.strobe}; g_rdy = {1'b0, bus_b.ready};
            g_run = {1'b0, bus_b.running}; g_cnt = {4'h0, bus_b.count[e.ech*4 +: 4]};
            g_crdy = bus_b.cfg_ready;
        end
        chk(e.id, "strobe", {4'h0, g_stb}, {4'h0, e.e_stb});
        chk(e.id, "ready", {4'h0, g_rdy}, {4'h0, e.e_rdy});
        chk(e.id, "running", {4'h0, g_run}, {4'h0, e.e_run});
        chk(e.id, "count", g_cnt, e.e_cnt);
        chk(e.id, "cfg_ready", {7'h0, g_crdy}, {7'h0, e.e_crdy});
    endtask

    initial begin
        int commits;
        rst = 1'b0;
        bus_a.tick = '0; bus_a.cfg_valid = 1'b0; bus_a.cfg_chan = '0;
        bus_a.cfg_period = '0; bus_a.cfg_oneshot = 1'b0; bus_a.cfg_start = 1'b0;
        bus_b.tick = '0; bus_b.cfg_valid = 1'b0; bus_b.cfg_chan = '0;
        bus_b.cfg_period = '0; bus_b.cfg_oneshot = 1'b0; bus_b.cfg_start = 1'b0;

        // reset and release
        tab.push_back(mk(0, 1'b0, 4'h0, 0, 2'd0, 8'd0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 8'd0, 0));
        tab.push_back(mk(1, 1'b0, 4'h0, 0, 2'd0, 8'd0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 8'd0, 0));
        tab.push_back(mk(0, 1'b1, 4'h0, 0, 2'd0, 8'd0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 8'd0, 1));
        // A: ch0 P=3 periodic, tick held
        tab.push_back(cf(0, 2'd0, 8'd3, 0, 1, 4'h0, 4'b0001, 4'b0001, 0, 8'd0));
        for (int i = 1; i <= 9; i++)
            tab.push_back(tk(0, 4'b0001, (i % 3 == 0) ? 4'b0001 : 4'b0000, 4'b0001,
                             4'b0001, 0, 8'(i % 3)));
        tab.push_back(tk(0, 4'b0000, 4'h0, 4'b0001, 4'b0001, 0, 8'd0));
        // A: ch2 one-shot P=4, six ticks
        tab.push_back(cf(0, 2'd2, 8'd4, 1, 1, 4'h0, 4'b0101, 4'b0101, 2, 8'd0));
        for (int i = 1; i <= 6; i++)
            tab.push_back(tk(0, 4'b0100, (i == 4) ? 4'b0100 : 4'b0000,
                             (i < 4) ? 4'b0101 : 4'b0001, (i < 4) ? 4'b0101 : 4'b0001,
                             2, (i < 4) ? 8'(i) : 8'd0));
        // A: config collides with terminal tick on ch0, then stop and dropped tick
        tab.push_back(tk(0, 4'b0001, 4'h0, 4'b0001, 4'b0001, 0, 8'd1));
        tab.push_back(tk(0, 4'b0001, 4'h0, 4'b0001, 4'b0001, 0, 8'd2));
        tab.push_back(mk(0, 1'b1, 4'b0001, 1, 2'd0, 8'd3, 0, 1, 4'h0, 4'b0001, 4'b0001, 0, 8'd0, 1));
        tab.push_back(tk(0, 4'b0001, 4'h0, 4'b0001, 4'b0001, 0, 8'd1));
        tab.push_back(cf(0, 2'd0, 8'd3, 0, 0, 4'h0, 4'b0000, 4'b0000, 0, 8'd0));
        tab.push_back(tk(0, 4'b0001, 4'h0, 4'b0000, 4'b0000, 0, 8'd0));
        // B: ch1 P=2 with two-stage latency, tick held
        tab.push_back(cf(1, 2'd1, 8'd2, 0, 1, 4'h0, 4'b0010, 4'b0010, 1, 8'd0));
        for (int i = 1; i <= 12; i++)
            tab.push_back(tk(1, 4'b0010, (i % 6 == 0) ? 4'b0010 : 4'b0000,
                             (i % 3 == 0) ? 4'b0010 : 4'b0000, 4'b0010, 1, 8'((i / 3) % 2)));
        tab.push_back(tk(1, 4'b0000, 4'h0, 4'b0010, 4'b0010, 1, 8'd0));
        // B: write to nonexistent channel 3 must change nothing
        tab.push_back(cf(1, 2'd3, 8'd5, 0, 1, 4'h0, 4'b0010, 4'b0010, 1, 8'd0));
        tab.push_back(cf(1, 2'd0, 8'd0, 0, 1, 4'h0, 4'b0011, 4'b0011, 0, 8'd0));

        for (int i = 0; i < tab.size(); i++)
            cycle_cmp(tab[i]);

        // B ch0: P=0 on a 4-bit counter, strobe only on the 16th committed tick
        for (int k = 0; k <= 50; k++) begin
            commits = (k + 1) / 3;
            cycle_cmp(tk(1, 4'b0001, (k % 3 == 2 && commits == 16) ? 4'b0001 : 4'b0000,
                         (k % 3 == 2) ? 4'b0011 : 4'b0010, 4'b0011, 0, 8'(commits % 16)));
        end

        // B ch2: reset while a tick is in flight, then P=1 after release
        cycle_cmp(cf(1, 2'd2, 8'd1, 0, 1, 4'h0, 4'b0111, 4'b0111, 2, 8'd0));
        cycle_cmp(tk(1, 4'b0100, 4'h0, 4'b0011, 4'b0111, 2, 8'd0));
        cycle_cmp(mk(1, 1'b0, 4'h0, 0, 2'd0, 8'd0, 0, 0, 4'h0, 4'h0, 4'h0, 2, 8'd0, 0));
        cycle_cmp(mk(1, 1'b1, 4'h0, 0, 2'd0, 8'd0, 0, 0, 4'h0, 4'h0, 4'h0, 2, 8'd0, 1));
        cycle_cmp(tk(1, 4'b0000, 4'h0, 4'h0, 4'h0, 2, 8'd0));
        cycle_cmp(cf(1, 2'd2, 8'd1, 0, 1, 4'h0, 4'b0100, 4'b0100, 2, 8'd0));
        cycle_cmp(tk(1, 4'b0100, 4'h0, 4'b0000, 4'b0100, 2, 8'd0));
        cycle_cmp(tk(1, 4'b0000, 4'h0, 4'b0000, 4'b0100, 2, 8'd0));
        cycle_cmp(tk(1, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 2, 8'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
